ccip_transmitter: RTL and testbench

CCIP_TRANSMITTER -- requirements
Module: ccip_transmitter

---
 rtl/ccip_transmitter.sv | 246 ++++++++++++++++++++++++
 tb/tb_ccip_transmitter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccip_transmitter.sv
// ccip_transmitter: delivers RPCs into per-flow CPU rings as CCI-P c1 WRLINE_I requests.
// Optional macro CCIP_TX_FLOW_CHECK_EN enables the sticky protocol/flow-range error.

package ccip_transmitter_pkg;
   localparam int unsigned CCIP_CLADDR_WIDTH = 42;
   localparam int unsigned CCIP_CLDATA_WIDTH = 512;
   localparam int unsigned LMAX_CCIP_BATCH   = 4;

   typedef logic [CCIP_CLADDR_WIDTH-1:0] t_ccip_clAddr;
   typedef logic [CCIP_CLDATA_WIDTH-1:0] t_ccip_clData;

   typedef enum logic [3:0] {
      eREQ_WRLINE_I = 4'h0,
      eREQ_WRLINE_M = 4'h1,
      eREQ_WRPUSH_I = 4'h2,
      eREQ_WRFENCE  = 4'h4,
      eREQ_INTR     = 4'h6
   } t_ccip_c1_req;

   typedef enum logic [1:0] {
      eVC_VA  = 2'b00,
      eVC_VL0 = 2'b01,
      eVC_VH0 = 2'b10,
      eVC_VH1 = 2'b11
   } t_ccip_vc;

   typedef enum logic [1:0] {
      eCL_LEN_1 = 2'b00,
      eCL_LEN_2 = 2'b01,
      eCL_LEN_4 = 2'b11
   } t_ccip_clLen;

   typedef struct packed {
      logic [5:0]   rsvd2;
      t_ccip_vc     vc_sel;
      logic         sop;
      logic         rsvd1;
      t_ccip_clLen  cl_len;
      t_ccip_c1_req req_type;
      logic [5:0]   rsvd0;
      t_ccip_clAddr address;
      logic [15:0]  mdata;
   } t_ccip_c1_ReqMemHdr;

   typedef struct packed {
      t_ccip_c1_ReqMemHdr hdr;
      t_ccip_clData       data;
      logic               valid;
   } t_if_ccip_c1_Tx;

   typedef struct packed {
      logic [31:0] rpc_id;
      logic [31:0] fn_id;
      logic [63:0] arg;
   } RpcIf;
endpackage

// Simple dual-port table, registered read; a colliding read returns the old word.
module single_clock_wr_ram #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADR_WIDTH  = 1
) (
   input  logic                  clk,
   input  logic [DATA_WIDTH-1:0] d,
   input  logic [ADR_WIDTH-1:0]  write_address,
   input  logic [ADR_WIDTH-1:0]  read_address,
   input  logic                  we,
   output logic [DATA_WIDTH-1:0] q
);
   logic [DATA_WIDTH-1:0] mem [0:(1<<ADR_WIDTH)-1];

   always_ff @(posedge clk) begin
      if (we) mem[write_address] <= d;
      q <= mem[read_address];
   end
endmodule

module ccip_transmitter
   import ccip_transmitter_pkg::*;
#(
   parameter int          NIC_ID            = 0,
   parameter int unsigned LMAX_NUM_OF_FLOWS = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [LMAX_NUM_OF_FLOWS-1:0] number_of_flows,
   input  t_ccip_clAddr                 tx_base_addr,
   input  logic [LMAX_CCIP_BATCH-1:0]   l_tx_batch_size,
   input  logic                         start,
   input  logic                         initialize,
   output logic                         initialized,
   output logic                         error,
   input  logic                         sRx_c1TxAlmFull,
   output t_if_ccip_c1_Tx               sTx_c1,
   output logic                         ccip_tx_ready,
   input  RpcIf                         rpc_in,
   input  logic                         rpc_in_valid,
   input  logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_in
);
   localparam int unsigned PTR_W = 8;
   // Instance number only labels debug output; no logic depends on it.
   localparam int unused_nic_id = NIC_ID;

   typedef logic [LMAX_NUM_OF_FLOWS-1:0] flow_t;
   typedef logic [PTR_W-1:0]             ptr_t;
   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} init_state_t;

   init_state_t        state, state_next;
   flow_t              init_addr, init_addr_next;
   logic               init_we_c;
   logic               accept_c, flow_ok_c;
   logic               s1_valid, s2_valid, wb_valid;
   RpcIf               s1_rpc;
   flow_t              s1_flow, s2_flow, wb_flow;
   ptr_t               s2_ptr_next, wb_ptr;
   ptr_t               tbl_q, tbl_d_c, s1_ptr_c, s1_ptr_next_c, ptr_wrap_c;
   flow_t              tbl_wr_addr_c;
   logic               tbl_we_c;
   t_ccip_clAddr       addr_c;
   t_ccip_c1_ReqMemHdr hdr_c, s2_hdr;
   t_ccip_clData       s2_data;

   // Table-clear FSM
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         init_addr   <= '0;
         initialized <= 1'b0;
      end else begin
         state       <= state_next;
         init_addr   <= init_addr_next;
         initialized <= (state_next == S_DONE);
      end
   end

   always_comb begin
      state_next     = state;
      init_addr_next = init_addr;
      init_we_c      = 1'b0;
      unique case (state)
         S_IDLE:  if (initialize) state_next = S_CLEAR;
         S_CLEAR: begin
            init_we_c      = 1'b1;
            init_addr_next = flow_t'(init_addr + 1'b1);
            if (init_addr == '1) state_next = S_DONE;
         end
         default: ;
      endcase
   end

   assign ccip_tx_ready = start & initialized & ~sRx_c1TxAlmFull;
   assign accept_c      = rpc_in_valid & ccip_tx_ready & flow_ok_c;

`ifdef CCIP_TX_FLOW_CHECK_EN
   assign flow_ok_c = (rpc_flow_id_in <= number_of_flows);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         error <= 1'b0;
      else if ((rpc_in_valid & ~ccip_tx_ready & start & initialized) |
               (rpc_in_valid & ccip_tx_ready & ~flow_ok_c))
         error <= 1'b1;
   end
`else
   flow_t unused_number_of_flows;
   assign unused_number_of_flows = number_of_flows;
   assign flow_ok_c = 1'b1;
   assign error     = 1'b0;
`endif

   single_clock_wr_ram #(
      .DATA_WIDTH (PTR_W),
      .ADR_WIDTH  (LMAX_NUM_OF_FLOWS)
   ) u_ptr_table (
      .clk           (clk),
      .d             (tbl_d_c),
      .write_address (tbl_wr_addr_c),
      .read_address  (rpc_flow_id_in),
      .we            (tbl_we_c),
      .q             (tbl_q)
   );

   assign tbl_we_c      = init_we_c | s2_valid;
   assign tbl_wr_addr_c = init_we_c ? init_addr : s2_flow;
   assign tbl_d_c       = init_we_c ? '0 : s2_ptr_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         wb_valid <= 1'b0;
      end else begin
         s1_valid <= accept_c;
         s2_valid <= s1_valid;
         wb_valid <= s2_valid;
      end
   end

   // Newest pointer wins: in-flight stage-2 result, then the write that raced the table read
   always_comb begin
      s1_ptr_c = tbl_q;
      if (s2_valid && (s2_flow == s1_flow))
         s1_ptr_c = s2_ptr_next;
      else if (wb_valid && (wb_flow == s1_flow))
         s1_ptr_c = wb_ptr;
   end

   assign ptr_wrap_c    = ptr_t'((16'(1) << l_tx_batch_size) - 16'd1);
   assign s1_ptr_next_c = (s1_ptr_c == ptr_wrap_c) ? '0 : ptr_t'(s1_ptr_c + 1'b1);
   assign addr_c        = t_ccip_clAddr'(tx_base_addr
                        + (t_ccip_clAddr'(s1_flow) << l_tx_batch_size)
                        + t_ccip_clAddr'(s1_ptr_c));

   always_comb begin
      hdr_c          = '0;
      hdr_c.req_type = eREQ_WRLINE_I;
      hdr_c.vc_sel   = eVC_VA;
      hdr_c.cl_len   = eCL_LEN_1;
      hdr_c.sop      = 1'b1;
      hdr_c.address  = addr_c;
   end

   always_ff @(posedge clk) begin
      if (accept_c) begin
         s1_rpc  <= rpc_in;
         s1_flow <= rpc_flow_id_in;
      end
      if (s1_valid) begin
         s2_hdr      <= hdr_c;
         s2_data     <= t_ccip_clData'(s1_rpc);
         s2_flow     <= s1_flow;
         s2_ptr_next <= s1_ptr_next_c;
      end
      if (s2_valid) begin
         wb_flow <= s2_flow;
         wb_ptr  <= s2_ptr_next;
      end
   end

   always_comb begin
      sTx_c1       = '0;
      sTx_c1.hdr   = s2_hdr;
      sTx_c1.data  = s2_data;
      sTx_c1.valid = s2_valid;
   end
endmodule

// File: tb/tb_ccip_transmitter.sv
// Directed self-checking bench for ccip_transmitter (2-bit flow id, base 0x1000, L=2).
module tb_ccip_transmitter;
   import ccip_transmitter_pkg::*;

   localparam int unsigned LF = 2;

   logic                       clk = 1'b0;
   logic                       reset;
   logic [LF-1:0]              number_of_flows = 2'd3;
   t_ccip_clAddr               tx_base_addr = 42'h1000;
   logic [LMAX_CCIP_BATCH-1:0] l_tx_batch_size = 4'd2;
   logic                       start = 1'b1;
   logic                       initialize = 1'b0;
   logic                       initialized, error;
   logic                       sRx_c1TxAlmFull = 1'b0;
   t_if_ccip_c1_Tx             sTx_c1;
   logic                       ccip_tx_ready;
   RpcIf                       rpc_in = '0;
   logic                       rpc_in_valid = 1'b0;
   logic [LF-1:0]              rpc_flow_id_in = '0;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int seq = 0;

   typedef struct {
      int                 cyc;
      t_ccip_c1_ReqMemHdr hdr;
      t_ccip_clData       data;
   } req_t;
   req_t got[$];

   ccip_transmitter #(.NIC_ID(0), .LMAX_NUM_OF_FLOWS(LF)) dut (
      .clk             (clk),
      .reset           (reset),
      .number_of_flows (number_of_flows),
      .tx_base_addr    (tx_base_addr),
      .l_tx_batch_size (l_tx_batch_size),
      .start           (start),
      .initialize      (initialize),
      .initialized     (initialized),
      .error           (error),
      .sRx_c1TxAlmFull (sRx_c1TxAlmFull),
      .sTx_c1          (sTx_c1),
      .ccip_tx_ready   (ccip_tx_ready),
      .rpc_in          (rpc_in),
      .rpc_in_valid    (rpc_in_valid),
      .rpc_flow_id_in  (rpc_flow_id_in)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      req_t e;
      if (sTx_c1.valid === 1'b1) begin
         e.cyc  = cyc;
         e.hdr  = sTx_c1.hdr;
         e.data = sTx_c1.data;
         got.push_back(e);
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic RpcIf mk_rpc(input int i);
      RpcIf r;
      r.rpc_id = 32'(32'hA000_0000 + i);
      r.fn_id  = 32'(32'h0000_00F0 + i);
      r.arg    = {32'(32'hDEAD_0000 + i), 32'(32'h1234_0000 + i)};
      return r;
   endfunction

   function automatic t_ccip_c1_ReqMemHdr exp_hdr(input t_ccip_clAddr a);
      t_ccip_c1_ReqMemHdr h;
      h          = '0;
      h.req_type = eREQ_WRLINE_I;
      h.vc_sel   = eVC_VA;
      h.cl_len   = eCL_LEN_1;
      h.sop      = 1'b1;
      h.address  = a;
      return h;
   endfunction

   // Drives one RPC per listed flow, with 'gap' idle cycles between them, then drains
   task automatic send(input int flows[$], input int gap, output int acc[$], output RpcIf rs[$]);
      acc = {};
      rs  = {};
      foreach (flows[i]) begin
         rpc_in         = mk_rpc(seq);
         rpc_flow_id_in = LF'(flows[i]);
         rpc_in_valid   = 1'b1;
         acc.push_back(cyc);
         rs.push_back(rpc_in);
         seq++;
         tick();
         rpc_in_valid = 1'b0;
         if (i != flows.size() - 1) tick(gap);
      end
      tick(5);
   endtask

   task automatic do_reinit();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick();
      initialize = 1'b1;
      tick();
      initialize = 1'b0;
      tick(6);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(2);
      checks++; if (sTx_c1.valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b required=0", sTx_c1.valid); end
      checks++; if (initialized !== 1'b0) begin failures++; $display("FAIL reset_initialized got=%b required=0", initialized); end
      checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b required=0", error); end
      checks++; if (ccip_tx_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b required=0", ccip_tx_ready); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_init();
      got = {};
      initialize = 1'b1;
      tick();
      initialize = 1'b0;
      tick(3);
      checks++; if (initialized !== 1'b0) begin failures++; $display("FAIL init_early got=%b required=0", initialized); end
      checks++; if (ccip_tx_ready !== 1'b0) begin failures++; $display("FAIL init_ready_early got=%b required=0", ccip_tx_ready); end
      tick();
      checks++; if (initialized !== 1'b1) begin failures++; $display("FAIL init_done got=%b required=1", initialized); end
      checks++; if (ccip_tx_ready !== 1'b1) begin failures++; $display("FAIL init_ready got=%b required=1", ccip_tx_ready); end
      initialize = 1'b1;
      tick();
      initialize = 1'b0;
      tick(6);
      checks++; if (initialized !== 1'b1) begin failures++; $display("FAIL init_second got=%b required=1", initialized); end
      checks++; if (got.size() != 0) begin failures++; $display("FAIL init_no_req got=%0d required=0", got.size()); end
   endtask

   task automatic test_single();
      int acc[$]; RpcIf rs[$];
      int fl[$] = '{1};
      t_ccip_clAddr exp[$] = '{42'h1004};
      got = {};
      send(fl, 0, acc, rs);
      checks++; if (got.size() != exp.size()) begin failures++; $display("FAIL single_count got=%0d required=%0d", got.size(), exp.size()); end
      foreach (exp[i]) if (i < got.size()) begin
         checks++; if (got[i].hdr !== exp_hdr(exp[i])) begin failures++; $display("FAIL single_hdr[%0d] got=%h required=%h", i, got[i].hdr, exp_hdr(exp[i])); end
         checks++; if (got[i].data !== t_ccip_clData'(rs[i])) begin failures++; $display("FAIL single_data[%0d] got=%h required=%h", i, got[i].data, t_ccip_clData'(rs[i])); end
         checks++; if (got[i].cyc != acc[i] + 2) begin failures++; $display("FAIL single_latency[%0d] got=%0d required=%0d", i, got[i].cyc, acc[i] + 2); end
      end
   endtask

   task automatic test_back_to_back();
      int acc[$]; RpcIf rs[$];
      int fl[$] = '{0, 0, 0, 0, 0};
      t_ccip_clAddr exp[$] = '{42'h1000, 42'h1001, 42'h1002, 42'h1003, 42'h1000};
      do_reinit();
      got = {};
      send(fl, 0, acc, rs);
      checks++; if (got.size() != exp.size()) begin failures++; $display("FAIL b2b_count got=%0d required=%0d", got.size(), exp.size()); end
      foreach (exp[i]) if (i < got.size()) begin
         checks++; if (got[i].hdr !== exp_hdr(exp[i])) begin failures++; $display("FAIL b2b_hdr[%0d] got=%h required=%h", i, got[i].hdr, exp_hdr(exp[i])); end
         checks++; if (got[i].data !== t_ccip_clData'(rs[i])) begin failures++; $display("FAIL b2b_data[%0d] got=%h required=%h", i, got[i].data, t_ccip_clData'(rs[i])); end
         checks++; if (got[i].cyc != acc[i] + 2) begin failures++; $display("FAIL b2b_latency[%0d] got=%0d required=%0d", i, got[i].cyc, acc[i] + 2); end
      end
   endtask

   // A repeated initialize must not clear pointers: flow 0 continues at slot 1
   task automatic test_reinit_ignored();
      int acc[$]; RpcIf rs[$];
      int fl[$] = '{0};
      initialize = 1'b1;
      tick();
      initialize = 1'b0;
      tick(6);
      got = {};
      send(fl, 0, acc, rs);
      checks++; if (got.size() != 1) begin failures++; $display("FAIL reinit_count got=%0d required=1", got.size()); end
      else begin
         checks++; if (got[0].hdr !== exp_hdr(42'h1001)) begin failures++; $display("FAIL reinit_hdr got=%h required=%h", got[0].hdr, exp_hdr(42'h1001)); end
      end
   endtask

   task automatic test_interleaved();
      int acc[$]; RpcIf rs[$];
      int fl[$] = '{0, 1, 0, 1};
      t_ccip_clAddr exp[$] = '{42'h1000, 42'h1004, 42'h1001, 42'h1005};
      do_reinit();
      got = {};
      send(fl, 0, acc, rs);
      checks++; if (got.size() != exp.size()) begin failures++; $display("FAIL inter_count got=%0d required=%0d", got.size(), exp.size()); end
      foreach (exp[i]) if (i < got.size()) begin
         checks++; if (got[i].hdr !== exp_hdr(exp[i])) begin failures++; $display("FAIL inter_hdr[%0d] got=%h required=%h", i, got[i].hdr, exp_hdr(exp[i])); end
         checks++; if (got[i].data !== t_ccip_clData'(rs[i])) begin failures++; $display("FAIL inter_data[%0d] got=%h required=%h", i, got[i].data, t_ccip_clData'(rs[i])); end
      end
   endtask

   // Same flow with one idle cycle between: flow 0 is at slot 2 after interleaving
   task automatic test_gap_forward();
      int acc[$]; RpcIf rs[$];
      int fl[$] = '{0, 0, 0};
      t_ccip_clAddr exp[$] = '{42'h1002, 42'h1003, 42'h1000};
      got = {};
      send(fl, 1, acc, rs);
      checks++; if (got.size() != exp.size()) begin failures++; $display("FAIL gap_count got=%0d required=%0d", got.size(), exp.size()); end
      foreach (exp[i]) if (i < got.size()) begin
         checks++; if (got[i].hdr !== exp_hdr(exp[i])) begin failures++; $display("FAIL gap_hdr[%0d] got=%h required=%h", i, got[i].hdr, exp_hdr(exp[i])); end
         checks++; if (got[i].cyc != acc[i] + 2) begin failures++; $display("FAIL gap_latency[%0d] got=%0d required=%0d", i, got[i].cyc, acc[i] + 2); end
      end
   endtask

   // Flow 1 sits at slot 2; one RPC accepted, then almost-full holds the next one off
   task automatic test_backpressure();
      int acc;
      RpcIf ra;
      int fl[$] = '{1};
      int acc2[$]; RpcIf rs2[$];
      logic exp_err;
`ifdef CCIP_TX_FLOW_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      got = {};
      ra = mk_rpc(seq); seq++;
      rpc_in = ra; rpc_flow_id_in = 2'd1; rpc_in_valid = 1'b1; acc = cyc;
      tick();
      sRx_c1TxAlmFull = 1'b1;
      rpc_in = mk_rpc(seq); seq++;
      #1;
      checks++; if (ccip_tx_ready !== 1'b0) begin failures++; $display("FAIL bp_ready got=%b required=0", ccip_tx_ready); end
      tick(3);
      rpc_in_valid = 1'b0;
      checks++; if (error !== exp_err) begin failures++; $display("FAIL bp_error got=%b required=%b", error, exp_err); end
      tick(2);
      sRx_c1TxAlmFull = 1'b0;
      tick(3);
      checks++; if (got.size() != 1) begin failures++; $display("FAIL bp_count got=%0d required=1", got.size()); end
      else begin
         checks++; if (got[0].hdr !== exp_hdr(42'h1006)) begin failures++; $display("FAIL bp_hdr got=%h required=%h", got[0].hdr, exp_hdr(42'h1006)); end
         checks++; if (got[0].data !== t_ccip_clData'(ra)) begin failures++; $display("FAIL bp_data got=%h required=%h", got[0].data, t_ccip_clData'(ra)); end
         checks++; if (got[0].cyc != acc + 2) begin failures++; $display("FAIL bp_latency got=%0d required=%0d", got[0].cyc, acc + 2); end
      end
      got = {};
      send(fl, 0, acc2, rs2);
      checks++; if (got.size() != 1) begin failures++; $display("FAIL bp_resume_count got=%0d required=1", got.size()); end
      else begin
         checks++; if (got[0].hdr !== exp_hdr(42'h1007)) begin failures++; $display("FAIL bp_resume_hdr got=%h required=%h", got[0].hdr, exp_hdr(42'h1007)); end
      end
   endtask

   task automatic test_reset_midflight();
      got = {};
      rpc_in = mk_rpc(seq); seq++;
      rpc_flow_id_in = 2'd0; rpc_in_valid = 1'b1;
      tick();
      rpc_in_valid = 1'b0;
      reset = 1'b1;
      tick();
      checks++; if (sTx_c1.valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b required=0", sTx_c1.valid); end
      checks++; if (initialized !== 1'b0) begin failures++; $display("FAIL midrst_initialized got=%b required=0", initialized); end
      checks++; if (error !== 1'b0) begin failures++; $display("FAIL midrst_error got=%b required=0", error); end
      tick();
      reset = 1'b0;
      tick(5);
      checks++; if (got.size() != 0) begin failures++; $display("FAIL midrst_no_req got=%0d required=0", got.size()); end
   endtask

   task automatic test_range();
      int acc[$]; RpcIf rs[$];
      int fl[$] = '{3};
      do_reinit();
      number_of_flows = 2'd1;
      got = {};
      send(fl, 0, acc, rs);
`ifdef CCIP_TX_FLOW_CHECK_EN
      checks++; if (got.size() != 0) begin failures++; $display("FAIL range_dropped got=%0d required=0", got.size()); end
      checks++; if (error !== 1'b1) begin failures++; $display("FAIL range_error got=%b required=1", error); end
      reset = 1'b1;
      tick();
      checks++; if (error !== 1'b0) begin failures++; $display("FAIL range_error_reset got=%b required=0", error); end
      reset = 1'b0;
      tick();
`else
      checks++; if (got.size() != 1) begin failures++; $display("FAIL range_count got=%0d required=1", got.size()); end
      else begin
         checks++; if (got[0].hdr !== exp_hdr(42'h100C)) begin failures++; $display("FAIL range_hdr got=%h required=%h", got[0].hdr, exp_hdr(42'h100C)); end
      end
      checks++; if (error !== 1'b0) begin failures++; $display("FAIL range_error got=%b required=0", error); end
`endif
      number_of_flows = 2'd3;
   endtask

   initial begin
      reset = 1'b1;
      test_reset();
      test_init();
      test_single();
      test_back_to_back();
      test_reinit_ignored();
      test_interleaved();
      test_gap_forward();
      test_backpressure();
      test_reset_midflight();
      test_range();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
